// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: state encodings, opcodes, ALU function codes.
// Used by the control unit and by datapath-level benches.
package cpu_isa_pkg;

  localparam int ST_W = 5;

  typedef enum logic [ST_W-1:0] {
    S_FETCH0 = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,
    S_ALU_Y  = 5'd5,
    S_ALU_X  = 5'd6,
    S_LD0    = 5'd7,
    S_LD1    = 5'd8,
    S_LD2    = 5'd9,
    S_LD3    = 5'd10,
    S_ST0    = 5'd11,
    S_ST1    = 5'd12,
    S_ST2    = 5'd13,
    S_JMP    = 5'd14,
    S_HALT   = 5'd15
  } state_e;

  localparam logic [6:0] OPC_ADD   = 7'h00;
  localparam logic [6:0] OPC_SUB   = 7'h01;
  localparam logic [6:0] OPC_AND   = 7'h02;
  localparam logic [6:0] OPC_OR    = 7'h03;
  localparam logic [6:0] OPC_NEG   = 7'h04;
  localparam logic [6:0] OPC_MOV   = 7'h06;
  localparam logic [6:0] OPC_LOAD  = 7'h10;
  localparam logic [6:0] OPC_STORE = 7'h11;
  localparam logic [6:0] OPC_JMP   = 7'h20;
  localparam logic [6:0] OPC_BZ    = 7'h21;
  localparam logic [6:0] OPC_HALT  = 7'h7F;

  localparam logic [2:0] FSEL_ADD  = 3'd0;
  localparam logic [2:0] FSEL_PASS = 3'd6;

  typedef enum logic [2:0] {
    OC_ALU, OC_LOAD, OC_STORE, OC_JMP, OC_BZ, OC_HALT, OC_ILL
  } opc_class_e;

  // Where DECODE branches to; BZ consults the zero flag latched by the last ALU op.
  function automatic state_e decode_target(opc_class_e c, logic z);
    case (c)
      OC_ALU:   return S_ALU_Y;
      OC_LOAD:  return S_LD0;
      OC_STORE: return S_ST0;
      OC_JMP:   return S_JMP;
      OC_BZ:    return z ? S_JMP : S_FETCH0;
      default:  return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/cpu_opc_decode.sv
// Classifies the 7-bit opcode into the instruction class that steers DECODE.
// Purely combinational.
module cpu_opc_decode
  import cpu_isa_pkg::*;
(
  input  logic [6:0] opc,
  output opc_class_e opc_class
);

  always_comb begin
    opc_class = OC_ILL;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND,
      OPC_OR, OPC_NEG, OPC_MOV: opc_class = OC_ALU;
      OPC_LOAD:                 opc_class = OC_LOAD;
      OPC_STORE:                opc_class = OC_STORE;
      OPC_JMP:                  opc_class = OC_JMP;
      OPC_BZ:                   opc_class = OC_BZ;
      OPC_HALT:                 opc_class = OC_HALT;
      default:                  opc_class = OC_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control FSM: fetch/decode/execute sequencing with Moore-decoded strobes.
// Holds state, the latched zero flag and the sticky illegal-opcode flag.
module cpu_control_unit
  import cpu_isa_pkg::*;
#(
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opc,
  input  logic [2:0]         opd1,
  input  logic [2:0]         opd2,
  input  logic [2:0]         opd3,
  input  logic               Z_det,
  input  logic               C,
  input  logic               V,
  input  logic               S,
  output logic               ldPC,
  output logic               ldIR,
  output logic               ldMAR,
  output logic               ldtmp,
  output logic               ldMDRZ,
  output logic               ldMDRdata,
  output logic               rd_mem,
  output logic               wr_mem,
  output logic               rd_reg,
  output logic               wr_reg,
  output logic               ldALU,
  output logic               ldXPC,
  output logic               ldYPC,
  output logic               ldXtmp,
  output logic               ldYtmp,
  output logic               ldXreg,
  output logic               ldYreg,
  output logic               ldXmem,
  output logic               ldYmem,
  output logic               ldXtmp2,
  output logic               ldYtmp2,
  output logic [2:0]         wr_regA,
  output logic [2:0]         rd_regA,
  output logic [2:0]         fsel,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic               err
);

  state_e     st, nxt;
  opc_class_e opc_class;
  logic       zflag;

  // Carry/overflow/sign are observed by the datapath only.
  logic unused_flags;
  assign unused_flags = ^{C, V, S};

  cpu_opc_decode u_dec (
    .opc       (opc),
    .opc_class (opc_class)
  );

  always_comb begin
    nxt = st;
    case (st)
      S_FETCH0: nxt = S_FETCH1;
      S_FETCH1: nxt = S_FETCH2;
      S_FETCH2: nxt = S_FETCH3;
      S_FETCH3: nxt = S_DECODE;
      S_DECODE: nxt = decode_target(opc_class, zflag);
      S_ALU_Y:  nxt = S_ALU_X;
      S_ALU_X:  nxt = S_FETCH0;
      S_LD0:    nxt = S_LD1;
      S_LD1:    nxt = S_LD2;
      S_LD2:    nxt = S_LD3;
      S_LD3:    nxt = S_FETCH0;
      S_ST0:    nxt = S_ST1;
      S_ST1:    nxt = S_ST2;
      S_ST2:    nxt = S_FETCH0;
      S_JMP:    nxt = S_FETCH0;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= S_FETCH0;
      zflag  <= 1'b0;
      err    <= 1'b0;
      halted <= 1'b0;
    end else begin
      st     <= nxt;
      halted <= (nxt == S_HALT);
      if (st == S_ALU_X)
        zflag <= Z_det;
      if (st == S_DECODE && opc_class == OC_ILL)
        err <= 1'b1;
    end
  end

  assign state = STATE_W'(st);

  always_comb begin
    ldPC = 1'b0; ldIR = 1'b0; ldMAR = 1'b0; ldtmp = 1'b0;
    ldMDRZ = 1'b0; ldMDRdata = 1'b0;
    rd_mem = 1'b0; wr_mem = 1'b0; rd_reg = 1'b0; wr_reg = 1'b0; ldALU = 1'b0;
    ldXPC = 1'b0; ldYPC = 1'b0; ldXtmp = 1'b0; ldYtmp = 1'b0;
    ldXreg = 1'b0; ldYreg = 1'b0; ldXmem = 1'b0; ldYmem = 1'b0;
    ldXtmp2 = 1'b0; ldYtmp2 = 1'b0;
    wr_regA = 3'd0; rd_regA = 3'd0; fsel = 3'd0;
    case (st)
      S_FETCH0: begin ldXPC = 1'b1; fsel = FSEL_PASS; ldALU = 1'b1; ldMAR = 1'b1; end
      S_FETCH1: rd_mem = 1'b1;
      S_FETCH2: begin ldIR = 1'b1; ldYtmp2 = 1'b1; end
      S_FETCH3: begin ldXPC = 1'b1; fsel = FSEL_ADD; ldALU = 1'b1; ldPC = 1'b1; end
      S_ALU_Y:  begin rd_reg = 1'b1; rd_regA = opd3; ldYreg = 1'b1; end
      S_ALU_X: begin
        rd_reg = 1'b1; rd_regA = opd2; ldXreg = 1'b1; ldALU = 1'b1;
        wr_reg = 1'b1; wr_regA = opd1; fsel = opc[2:0];
      end
      S_LD0, S_ST0: begin
        rd_reg = 1'b1; rd_regA = opd2; ldXreg = 1'b1;
        fsel = FSEL_PASS; ldALU = 1'b1; ldMAR = 1'b1;
      end
      S_LD1:    rd_mem = 1'b1;
      S_LD2:    ldMDRdata = 1'b1;
      S_LD3: begin
        ldXmem = 1'b1; fsel = FSEL_PASS; ldALU = 1'b1; wr_reg = 1'b1; wr_regA = opd1;
      end
      S_ST1: begin
        rd_reg = 1'b1; rd_regA = opd1; ldXreg = 1'b1;
        fsel = FSEL_PASS; ldALU = 1'b1; ldMDRZ = 1'b1;
      end
      S_ST2:    wr_mem = 1'b1;
      S_JMP: begin
        rd_reg = 1'b1; rd_regA = opd1; ldXreg = 1'b1;
        fsel = FSEL_PASS; ldALU = 1'b1; ldPC = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus a random program
// checked against an instruction-level model of state paths, flags and latencies.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opc = 7'h00;
  logic [2:0] opd1 = 3'd0, opd2 = 3'd0, opd3 = 3'd0;
  logic       Z_det = 1'b0, C = 1'b0, V = 1'b0, S = 1'b0;
  logic ldPC, ldIR, ldMAR, ldtmp, ldMDRZ, ldMDRdata, rd_mem, wr_mem, rd_reg, wr_reg, ldALU;
  logic ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg, ldXmem, ldYmem, ldXtmp2, ldYtmp2;
  logic [2:0] wr_regA, rd_regA, fsel;
  logic [4:0] state;
  logic       halted, err;

  int checks = 0;
  int errors = 0;
  logic zflag_m = 1'b0;
  logic err_m = 1'b0;

  cpu_control_unit #(.STATE_W(5)) dut (
    .clk(clk), .reset(reset), .opc(opc), .opd1(opd1), .opd2(opd2), .opd3(opd3),
    .Z_det(Z_det), .C(C), .V(V), .S(S),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldtmp(ldtmp), .ldMDRZ(ldMDRZ),
    .ldMDRdata(ldMDRdata), .rd_mem(rd_mem), .wr_mem(wr_mem), .rd_reg(rd_reg),
    .wr_reg(wr_reg), .ldALU(ldALU), .ldXPC(ldXPC), .ldYPC(ldYPC), .ldXtmp(ldXtmp),
    .ldYtmp(ldYtmp), .ldXreg(ldXreg), .ldYreg(ldYreg), .ldXmem(ldXmem), .ldYmem(ldYmem),
    .ldXtmp2(ldXtmp2), .ldYtmp2(ldYtmp2), .wr_regA(wr_regA), .rd_regA(rd_regA),
    .fsel(fsel), .state(state), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_alu(input logic [6:0] o);
    return o inside {7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h06};
  endfunction

  function automatic bit is_illegal(input logic [6:0] o);
    return !(is_alu(o) || o inside {7'h10, 7'h11, 7'h20, 7'h21, 7'h7F});
  endfunction

  // Instruction-level model: the ordered states an instruction visits.
  function automatic void build_path(input logic [6:0] o, input logic z, output int p[$]);
    p = {0, 1, 2, 3, 4};
    if (is_alu(o))            p = {p, 5, 6};
    else if (o == 7'h10)      p = {p, 7, 8, 9, 10};
    else if (o == 7'h11)      p = {p, 11, 12, 13};
    else if (o == 7'h20)      p = {p, 14};
    else if (o == 7'h21)      begin if (z) p = {p, 14}; end
    else                      p = {p, 15};
  endfunction

  // Starts at a negedge with the DUT expected in FETCH0; checks every cycle of one instruction.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic z);
    int p[$];
    int s;
    logic e_exp;
    build_path(o, zflag_m, p);
    opc = o; opd1 = a; opd2 = b; opd3 = c; Z_det = z;
    foreach (p[i]) begin
      s = p[i];
      e_exp = err_m | (is_illegal(o) && s == 15);
      checks++;
      if (int'(state) !== s) begin
        errors++; $display("FAIL path opc=%h step %0d: state=%0d want %0d", o, i, state, s);
      end
      checks++;
      if ($countones({ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg, ldXmem, ldYmem,
                      ldXtmp2, ldYtmp2}) > 1 || (rd_mem && wr_mem)) begin
        errors++; $display("FAIL bus_excl state=%0d: rd_mem=%b wr_mem=%b xy=%b", state,
                           rd_mem, wr_mem, {ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg,
                           ldXmem, ldYmem, ldXtmp2, ldYtmp2});
      end
      checks++;
      if (halted !== (s == 15) || err !== e_exp) begin
        errors++; $display("FAIL flags state=%0d: halted=%b err=%b want %b %b", s, halted, err,
                           (s == 15), e_exp);
      end
      case (s)
        0: begin
          checks++;
          if ({ldXPC, ldALU, ldMAR, fsel} !== {3'b111, 3'd6}) begin
            errors++; $display("FAIL fetch0: xpc/alu/mar/fsel=%b want 111110",
                               {ldXPC, ldALU, ldMAR, fsel});
          end
        end
        5: begin
          checks++;
          if (rd_regA !== c || ldYreg !== 1'b1 || rd_reg !== 1'b1) begin
            errors++; $display("FAIL alu_y: rd_regA=%0d ldYreg=%b want %0d 1", rd_regA, ldYreg, c);
          end
        end
        6: begin
          checks++;
          if (fsel !== o[2:0] || rd_regA !== b || wr_regA !== a || wr_reg !== 1'b1) begin
            errors++; $display("FAIL alu_x: fsel=%0d rd=%0d wr=%0d wr_reg=%b want %0d %0d %0d 1",
                               fsel, rd_regA, wr_regA, wr_reg, o[2:0], b, a);
          end
        end
        10: begin
          checks++;
          if (wr_regA !== a || ldXmem !== 1'b1 || wr_reg !== 1'b1) begin
            errors++; $display("FAIL ld3: wr_regA=%0d ldXmem=%b want %0d 1", wr_regA, ldXmem, a);
          end
        end
        12: begin
          checks++;
          if (rd_regA !== a || ldMDRZ !== 1'b1) begin
            errors++; $display("FAIL st1: rd_regA=%0d ldMDRZ=%b want %0d 1", rd_regA, ldMDRZ, a);
          end
        end
        13: begin
          checks++;
          if (wr_mem !== 1'b1) begin
            errors++; $display("FAIL st2: wr_mem=%b want 1", wr_mem);
          end
        end
        14: begin
          checks++;
          if (rd_regA !== a || ldPC !== 1'b1) begin
            errors++; $display("FAIL jmp: rd_regA=%0d ldPC=%b want %0d 1", rd_regA, ldPC, a);
          end
        end
        default: ;
      endcase
      @(posedge clk); @(negedge clk);
    end
    if (is_alu(o)) zflag_m = z;
    if (is_illegal(o)) err_m = 1'b1;
  endtask

  // Drives one instruction from FETCH0 and counts edges until FETCH0 comes back.
  task automatic measure(input logic [6:0] o, input logic z, input int want, input string nm);
    int n = 0;
    opc = o; opd1 = 3'd1; opd2 = 3'd2; opd3 = 3'd3; Z_det = z;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (state !== 5'd0 && n < 40);
    if (is_alu(o)) zflag_m = z;
    checks++;
    if (n !== want) begin
      errors++; $display("FAIL latency_%s: %0d cycles want %0d", nm, n, want);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    zflag_m = 1'b0; err_m = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 5'd0 || err !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset: state=%0d err=%b halted=%b want 0 0 0", state, err, halted);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    run_instr(7'h00, 3'd1, 3'd2, 3'd3, 1'b0);
  endtask

  task automatic test_load_store_jmp();
    run_instr(7'h10, 3'd4, 3'd5, 3'd0, 1'b1);
    run_instr(7'h11, 3'd6, 3'd3, 3'd0, 1'b1);
    run_instr(7'h20, 3'd7, 3'd0, 3'd0, 1'b1);
  endtask

  task automatic test_latency();
    measure(7'h01, 1'b0, 7, "alu");
    measure(7'h10, 1'b0, 9, "load");
    measure(7'h11, 1'b0, 8, "store");
    measure(7'h20, 1'b0, 6, "jmp");
    run_instr(7'h03, 3'd1, 3'd1, 3'd1, 1'b1);
    measure(7'h21, 1'b0, 6, "bz_taken");
    run_instr(7'h03, 3'd1, 3'd1, 3'd1, 1'b0);
    measure(7'h21, 1'b1, 5, "bz_not_taken");
  endtask

  task automatic test_bz();
    run_instr(7'h02, 3'd2, 3'd3, 3'd4, 1'b1);
    run_instr(7'h21, 3'd5, 3'd0, 3'd0, 1'b0);
    run_instr(7'h10, 3'd1, 3'd2, 3'd0, 1'b0);
    run_instr(7'h11, 3'd1, 3'd2, 3'd0, 1'b0);
    run_instr(7'h21, 3'd6, 3'd0, 3'd0, 1'b0);
    run_instr(7'h06, 3'd2, 3'd3, 3'd4, 1'b0);
    run_instr(7'h21, 3'd6, 3'd0, 3'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [6:0] legal [10] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h06,
                               7'h10, 7'h11, 7'h20, 7'h21};
    for (int k = 0; k < 60; k++) begin
      run_instr(legal[$urandom_range(9)], 3'($urandom), 3'($urandom), 3'($urandom),
                1'($urandom));
    end
  endtask

  task automatic test_halt();
    run_instr(7'h7F, 3'd0, 3'd0, 3'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 5'd15 || halted !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL halt_hold: state=%0d halted=%b err=%b want 15 1 0", state, halted, err);
    end
    apply_reset();
  endtask

  task automatic test_illegal();
    run_instr(7'h55, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      opc = 7'($urandom);
      checks++;
      if (state !== 5'd15 || halted !== 1'b1 || err !== 1'b1) begin
        errors++; $display("FAIL illegal_hold cycle %0d: state=%0d halted=%b err=%b want 15 1 1",
                           k, state, halted, err);
      end
      @(posedge clk); @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 5'd0 || halted !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_from_halt: state=%0d halted=%b err=%b want 0 0 0",
                         state, halted, err);
    end
    @(negedge clk); reset = 1'b1;
    zflag_m = 1'b0; err_m = 1'b0;
  endtask

  task automatic test_reset_mid_ld2();
    run_instr(7'h00, 3'd1, 3'd1, 3'd1, 1'b1);
    opc = 7'h10; opd1 = 3'd4; opd2 = 3'd5;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (state !== 5'd9) begin
      errors++; $display("FAIL reach_ld2: state=%0d want 9", state);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 5'd0 || halted !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ld2: state=%0d halted=%b err=%b want 0 0 0",
                         state, halted, err);
    end
    @(negedge clk); reset = 1'b1;
    zflag_m = 1'b0; err_m = 1'b0;
    run_instr(7'h21, 3'd3, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store_jmp();
    test_latency();
    test_bz();
    test_random();
    test_halt();
    test_illegal();
    test_reset_mid_ld2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
